// File: rtl/window_pkg.sv
// Shared sizing helpers and types for the sliding-window accumulator.
package window_pkg;

    // Sum width that holds DEPTH samples of WIDTH bits with one spare bit
    function automatic int sum_width(input int width, input int depth);
        return width + $clog2(depth) + 1;
    endfunction

    // Fill counter width that can represent 0..DEPTH inclusive
    function automatic int fill_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_FILL_W = fill_width(DEFAULT_DEPTH);
    localparam int DEFAULT_SUM_W = sum_width(DEFAULT_WIDTH, DEFAULT_DEPTH);

    typedef logic [DEFAULT_FILL_W-1:0] fill_t;

endpackage

// File: rtl/window_shift.sv
// DEPTH-slot sample shift register with enable and synchronous flush.
// The oldest slot is exposed combinationally so the accumulator can retire it.
module window_shift
    import window_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] oldest
);

    logic [WIDTH-1:0] slots [DEPTH];

    // Flush zeroes every slot; a simultaneous shift lands din in the newest slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 1; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            slots[0] <= shift_en ? din : '0;
        end else if (shift_en) begin
            for (int i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
            slots[0] <= din;
        end
    end

    assign oldest = slots[DEPTH-1];

endmodule

// File: rtl/window_sum.sv
// Sliding-window accumulator: registered sum of the last DEPTH accepted
// samples, a saturating fill count and a window-full flag.
module window_sum
    import window_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int SUM_W = sum_width(WIDTH, DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             a,
    input  logic                         clear,
    output logic [SUM_W-1:0]             sum,
    output logic                         sum_valid,
    output logic [fill_width(DEPTH)-1:0] fill
);

    localparam int FILL_W = fill_width(DEPTH);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

    logic             accept;
    logic [WIDTH-1:0] oldest;
    logic [SUM_W-1:0] sum_next;
    logic [FILL_W-1:0] fill_next;
    logic             valid_next;

    assign accept = in_valid && !clear;

    window_shift #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (in_valid),
        .flush    (clear),
        .din      (a),
        .oldest   (oldest)
    );

    // Next-state: clear beats accept; the retired oldest sample is always part of sum
    always_comb begin
        sum_next   = sum;
        fill_next  = fill;
        valid_next = sum_valid;
        if (clear) begin
            sum_next   = in_valid ? SUM_W'(a) : '0;
            fill_next  = in_valid ? FILL_ONE : '0;
            valid_next = 1'b0;
        end else if (accept) begin
            sum_next   = sum + SUM_W'(a) - SUM_W'(oldest);
            fill_next  = (fill == FILL_FULL) ? fill : fill + FILL_ONE;
            valid_next = (fill_next == FILL_FULL);
        end
    end

    // Accumulator, fill counter and full flag registered together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum       <= '0;
            fill      <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum       <= sum_next;
            fill      <= fill_next;
            sum_valid <= valid_next;
        end
    end

endmodule
